// File: rtl/globallocal_peer.sv
// Peer transactor for GlobalLocal: sends programmable arithmetic bursts on b_in
// and buffers words received on b_out in a small FIFO drained by a host.
module globallocal_peer #(
    parameter int unsigned        DEPTH = 4,
    parameter logic signed [31:0] STEP  = 32'sd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] len_i,
    input  logic [31:0] seed_i,
    output logic [31:0] b_in_o,
    output logic        b_in_sync_o,
    input  logic        b_in_notify_i,
    input  logic [31:0] b_out_i,
    input  logic        b_out_notify_i,
    output logic        b_out_sync_o,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        tx_busy_o,
    output logic [15:0] tx_count_o,
    output logic [15:0] rx_count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    tx_state_e   state_q;
    logic [31:0] b_in_q;
    logic        b_in_sync_q;
    logic        tx_busy_q;
    logic [15:0] remaining_q;
    logic [15:0] tx_count_q;
    logic        tx_xfer_s;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [15:0]   rx_count_q;
    logic          push_s;
    logic          pop_s;

    assign tx_xfer_s    = b_in_sync_q & b_in_notify_i;
    assign b_out_sync_o = (count_q < (AW+1)'(DEPTH));
    assign rd_valid_o   = (count_q != '0);
    assign rd_data_o    = mem_q[rd_ptr_q];
    assign push_s       = b_out_notify_i & b_out_sync_o;
    assign pop_s        = rd_valid_o & rd_ready_i;

    assign b_in_o      = b_in_q;
    assign b_in_sync_o = b_in_sync_q;
    assign tx_busy_o   = tx_busy_q;
    assign tx_count_o  = tx_count_q;
    assign rx_count_o  = rx_count_q;

    // Transmit FSM: loads a burst in IDLE, steps the word on each completed transfer in SEND.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= TX_IDLE;
            b_in_q      <= 32'd0;
            b_in_sync_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            remaining_q <= 16'd0;
            tx_count_q  <= 16'd0;
        end else begin
            if (tx_xfer_s) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
            case (state_q)
                TX_IDLE: begin
                    if (start_i && (len_i != 16'd0)) begin
                        b_in_q      <= seed_i;
                        remaining_q <= len_i;
                        b_in_sync_q <= 1'b1;
                        tx_busy_q   <= 1'b1;
                        state_q     <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_xfer_s) begin
                        if (remaining_q == 16'd1) begin
                            b_in_sync_q <= 1'b0;
                            tx_busy_q   <= 1'b0;
                            state_q     <= TX_IDLE;
                        end else begin
                            b_in_q      <= b_in_q + STEP;
                            remaining_q <= remaining_q - 16'd1;
                        end
                    end
                end
                default: begin
                    b_in_sync_q <= 1'b0;
                    tx_busy_q   <= 1'b0;
                    state_q     <= TX_IDLE;
                end
            endcase
        end
    end

    // Occupancy next state; a simultaneous push and pop cancels out.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - (AW+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Receive FIFO storage, pointers and the receive transfer counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_count_q <= 16'd0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= b_out_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
                rx_count_q      <= rx_count_q + 16'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_globallocal_peer.sv
// Self-checking bench for globallocal_peer: directed scenarios plus randomized
// traffic compared against a sequence/queue reference model.
module tb_globallocal_peer;
    localparam int unsigned DEPTH = 4;
    localparam int          STEP  = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] seed_i;
    logic [31:0] b_in_o;
    logic        b_in_sync_o;
    logic        b_in_notify_i;
    logic [31:0] b_out_i;
    logic        b_out_notify_i;
    logic        b_out_sync_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic        tx_busy_o;
    logic [15:0] tx_count_o;
    logic [15:0] rx_count_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: a burst is (seed, len, words sent so far); the FIFO is a queue.
    logic [31:0] m_seed;
    int unsigned m_len;
    int unsigned m_idx;
    logic [15:0] m_txc;
    logic [15:0] m_rxc;
    logic [31:0] q[$];

    globallocal_peer #(.DEPTH(DEPTH), .STEP(32'(STEP))) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .seed_i(seed_i),
        .b_in_o(b_in_o), .b_in_sync_o(b_in_sync_o), .b_in_notify_i(b_in_notify_i),
        .b_out_i(b_out_i), .b_out_notify_i(b_out_notify_i), .b_out_sync_o(b_out_sync_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .tx_busy_o(tx_busy_o), .tx_count_o(tx_count_o), .rx_count_o(rx_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] exp_b_in();
        int unsigned k;
        if (m_len == 0) return 32'd0;
        k = (m_idx < m_len) ? m_idx : (m_len - 1);
        return m_seed + 32'(STEP) * k;
    endfunction

    function automatic logic exp_busy();
        return (m_idx < m_len);
    endfunction

    task automatic model_reset();
        m_seed = 32'd0;
        m_len  = 0;
        m_idx  = 0;
        m_txc  = 16'd0;
        m_rxc  = 16'd0;
        q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic push;
        logic pop;
        push = b_out_notify_i && (q.size() < DEPTH);
        pop  = (q.size() != 0) && rd_ready_i;
        if (exp_busy()) begin
            if (b_in_notify_i) begin
                m_idx++;
                m_txc++;
            end
        end else if (start_i && (len_i != 16'd0)) begin
            m_seed = seed_i;
            m_len  = {16'd0, len_i};
            m_idx  = 0;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(b_out_i);
            m_rxc++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; len_i = 16'd0; seed_i = 32'd0;
        b_in_notify_i = 1'b0; b_out_i = 32'd0; b_out_notify_i = 1'b0; rd_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if (b_in_o !== 32'd0) begin failures++; $display("FAIL reset_b_in got=%0h exp=0", b_in_o); end
        checks++; if (b_in_sync_o !== 1'b0) begin failures++; $display("FAIL reset_b_in_sync got=%b exp=0", b_in_sync_o); end
        checks++; if (tx_busy_o !== 1'b0) begin failures++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy_o); end
        checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); end
        checks++; if (rd_data_o !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data_o); end
        checks++; if (b_out_sync_o !== 1'b1) begin failures++; $display("FAIL reset_b_out_sync got=%b exp=1", b_out_sync_o); end
        checks++; if (tx_count_o !== 16'd0 || rx_count_o !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", tx_count_o, rx_count_o); end
    endtask

    task automatic test_basic_burst();
        seed_i = 32'd10; len_i = 16'd3; start_i = 1'b1; b_in_notify_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (b_in_o !== 32'(10 + k)) begin failures++; $display("FAIL basic_word%0d got=%0d exp=%0d", k, b_in_o, 10 + k); end
            checks++; if (tx_busy_o !== 1'b1 || b_in_sync_o !== 1'b1) begin failures++; $display("FAIL basic_busy%0d got=%b%b exp=11", k, tx_busy_o, b_in_sync_o); end
            tick();
        end
        checks++; if (tx_busy_o !== 1'b0 || b_in_sync_o !== 1'b0) begin failures++; $display("FAIL basic_done got=%b%b exp=00", tx_busy_o, b_in_sync_o); end
        checks++; if (tx_count_o !== 16'd3) begin failures++; $display("FAIL basic_tx_count got=%0d exp=3", tx_count_o); end
        checks++; if (b_in_o !== 32'd12) begin failures++; $display("FAIL basic_last_hold got=%0d exp=12", b_in_o); end
        b_in_notify_i = 1'b0;
    endtask

    task automatic test_stalls_wrap();
        logic [31:0] sent[$];
        logic        pattern [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        seed_i = 32'h7FFF_FFFF; len_i = 16'd2; start_i = 1'b1; b_in_notify_i = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            start_i = (c == 0);
            seed_i  = (c == 0) ? 32'h1234 : 32'd0;
            len_i   = (c == 0) ? 16'd7 : 16'd0;
            b_in_notify_i = pattern[c];
            checks++; if (b_in_o !== exp_b_in()) begin failures++; $display("FAIL stall_hold%0d got=%0h exp=%0h", c, b_in_o, exp_b_in()); end
            if (b_in_sync_o && b_in_notify_i) sent.push_back(b_in_o);
            tick();
        end
        start_i = 1'b0; b_in_notify_i = 1'b0;
        checks++; if (sent.size() != 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", sent.size()); end
        else begin
            checks++; if (sent[0] !== 32'h7FFF_FFFF) begin failures++; $display("FAIL stall_word0 got=%0h exp=7fffffff", sent[0]); end
            checks++; if (sent[1] !== 32'h8000_0000) begin failures++; $display("FAIL stall_word1 got=%0h exp=80000000", sent[1]); end
        end
        checks++; if (tx_busy_o !== 1'b0) begin failures++; $display("FAIL stall_start_ignored busy got=%b exp=0", tx_busy_o); end
        checks++; if (tx_count_o !== 16'd5) begin failures++; $display("FAIL stall_tx_count got=%0d exp=5", tx_count_o); end
    endtask

    task automatic test_rx_fill();
        logic [31:0] popped[$];
        int          val = 1;
        rd_ready_i = 1'b0; b_out_notify_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            b_out_i = 32'(val);
            if (q.size() < DEPTH) val++;
            tick();
        end
        checks++; if (b_out_sync_o !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", b_out_sync_o); end
        checks++; if (rx_count_o !== 16'd4) begin failures++; $display("FAIL fill_rx_count got=%0d exp=4", rx_count_o); end
        checks++; if (rd_data_o !== 32'd1 || rd_valid_o !== 1'b1) begin failures++; $display("FAIL fill_head got=%0d/%b exp=1/1", rd_data_o, rd_valid_o); end
        rd_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            b_out_notify_i = (val <= 6);
            b_out_i = 32'(val);
            if (b_out_notify_i && q.size() < DEPTH) val++;
            if (rd_valid_o && rd_ready_i) popped.push_back(rd_data_o);
            tick();
        end
        b_out_notify_i = 1'b0; rd_ready_i = 1'b0;
        checks++; if (popped.size() != 6) begin failures++; $display("FAIL fill_pop_count got=%0d exp=6", popped.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (popped[k] !== 32'(k + 1)) begin failures++; $display("FAIL fill_order%0d got=%0d exp=%0d", k, popped[k], k + 1); end
            end
        end
        checks++; if (rx_count_o !== 16'd6) begin failures++; $display("FAIL fill_rx_total got=%0d exp=6", rx_count_o); end
    endtask

    task automatic test_full_pop();
        bit drained = 1'b0;
        rd_ready_i = 1'b0; b_out_notify_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            b_out_i = 32'hA0 + 32'(c);
            tick();
        end
        b_out_i = 32'hB0; rd_ready_i = 1'b1;
        checks++; if (b_out_sync_o !== 1'b0) begin failures++; $display("FAIL fullpop_sync_pre got=%b exp=0", b_out_sync_o); end
        tick();
        checks++; if (rx_count_o !== 16'd10) begin failures++; $display("FAIL fullpop_no_push got=%0d exp=10", rx_count_o); end
        checks++; if (rd_data_o !== 32'hA1) begin failures++; $display("FAIL fullpop_head got=%0h exp=a1", rd_data_o); end
        checks++; if (b_out_sync_o !== 1'b1) begin failures++; $display("FAIL fullpop_sync_back got=%b exp=1", b_out_sync_o); end
        rd_ready_i = 1'b0;
        tick();
        checks++; if (rx_count_o !== 16'd11 || b_out_sync_o !== 1'b0) begin failures++; $display("FAIL fullpop_push_next got=%0d/%b exp=11/0", rx_count_o, b_out_sync_o); end
        b_out_notify_i = 1'b0; rd_ready_i = 1'b1;
        for (int c = 0; c < 8 && !drained; c++) begin
            if (!rd_valid_o) drained = 1'b1;
            else tick();
        end
        rd_ready_i = 1'b0;
        checks++; if (!drained) begin failures++; $display("FAIL fullpop_drain got=valid exp=empty"); end
    endtask

    task automatic test_reset_mid_burst();
        seed_i = 32'd100; len_i = 16'd5; start_i = 1'b1; b_in_notify_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        model_reset();
        checks++; if (b_in_o !== 32'd0 || b_in_sync_o !== 1'b0 || tx_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_tx got=%0h/%b/%b exp=0/0/0", b_in_o, b_in_sync_o, tx_busy_o); end
        checks++; if (tx_count_o !== 16'd0 || rx_count_o !== 16'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", tx_count_o, rx_count_o); end
        checks++; if (b_out_sync_o !== 1'b1 || rd_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_fifo got=%b/%b exp=1/0", b_out_sync_o, rd_valid_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        seed_i = 32'd500; len_i = 16'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (b_in_o !== 32'd500 || tx_busy_o !== 1'b1) begin failures++; $display("FAIL midrst_restart got=%0d/%b exp=500/1", b_in_o, tx_busy_o); end
        tick();
        tick();
        checks++; if (tx_count_o !== 16'd2 || tx_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_count got=%0d/%b exp=2/0", tx_count_o, tx_busy_o); end
        b_in_notify_i = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            start_i        = ($urandom_range(0, 5) == 0);
            len_i          = 16'($urandom_range(0, 6));
            seed_i         = $urandom;
            b_in_notify_i  = $urandom_range(0, 1) == 1;
            b_out_i        = $urandom;
            b_out_notify_i = $urandom_range(0, 2) != 0;
            rd_ready_i     = $urandom_range(0, 2) != 0;
            checks++; if (b_in_o !== exp_b_in()) begin failures++; $display("FAIL rnd_b_in c=%0d got=%0h exp=%0h", c, b_in_o, exp_b_in()); end
            checks++; if (b_in_sync_o !== exp_busy() || tx_busy_o !== exp_busy()) begin failures++; $display("FAIL rnd_busy c=%0d got=%b%b exp=%b", c, b_in_sync_o, tx_busy_o, exp_busy()); end
            checks++; if (tx_count_o !== m_txc || rx_count_o !== m_rxc) begin failures++; $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, tx_count_o, rx_count_o, m_txc, m_rxc); end
            checks++; if (b_out_sync_o !== (q.size() < DEPTH) || rd_valid_o !== (q.size() != 0)) begin failures++; $display("FAIL rnd_flags c=%0d got=%b%b occ=%0d", c, b_out_sync_o, rd_valid_o, q.size()); end
            if (q.size() != 0) begin
                checks++; if (rd_data_o !== q[0]) begin failures++; $display("FAIL rnd_rd_data c=%0d got=%0h exp=%0h", c, rd_data_o, q[0]); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_stalls_wrap();
        test_rx_fill();
        test_full_pop();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
